// File: rtl/led_dimmer.sv
// 32-channel LED dimmer: 16-step PWM brightness with optional blink, driving
// active-low pins from a registered output stage.
module led_dimmer #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pattern_in,
  input  logic        ctrl_we,
  input  logic [31:0] ctrl_wdata,
  output logic [31:0] ctrl_rdata,
  output logic [31:0] led_out
);

  localparam int             PW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pcnt;
  logic [3:0]    r_pwm_cnt;
  logic [3:0]    r_blink_cnt;
  logic          r_phase;
  logic [3:0]    r_duty;
  logic          r_blink_en;
  logic [3:0]    r_period;
  logic [31:0]   r_led_out;

  logic          w_tick;
  logic          w_blink_upd;
  logic          w_pwm_on;
  logic          w_mask;
  logic          w_unused_wdata;

  assign w_tick      = (r_pcnt == PMAX);
  assign w_blink_upd = w_tick && (r_pwm_cnt == 4'd15);
  assign w_pwm_on    = (r_duty == 4'd15) ? 1'b1 : (r_pwm_cnt < r_duty);
  assign w_mask      = w_pwm_on & (~r_blink_en | r_phase);

  assign ctrl_rdata  = {r_phase, 19'b0, r_period, 3'b0, r_blink_en, r_duty};
  assign led_out     = r_led_out;

  assign w_unused_wdata = &{1'b0, ctrl_wdata[31:12], ctrl_wdata[7:5]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwm_cnt <= 4'd0;
    end else if (w_tick) begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
    end
  end

  // A control write restarts the blink sequence and overrides a same-cycle toggle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_duty      <= 4'd15;
      r_blink_en  <= 1'b0;
      r_period    <= 4'd0;
      r_blink_cnt <= 4'd0;
      r_phase     <= 1'b1;
    end else if (ctrl_we) begin
      r_duty      <= ctrl_wdata[3:0];
      r_blink_en  <= ctrl_wdata[4];
      r_period    <= ctrl_wdata[11:8];
      r_blink_cnt <= 4'd0;
      r_phase     <= 1'b1;
    end else if (w_blink_upd) begin
      if (r_blink_cnt == r_period) begin
        r_blink_cnt <= 4'd0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_led_out <= 32'hFFFF_FFFF;
    end else begin
      r_led_out <= ~(pattern_in & {32{w_mask}});
    end
  end

endmodule

// File: doc/led_dimmer.md
LED_DIMMER -- requirements
Module: led_dimmer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, meaning clk cycles per PWM tick (legal range >= 2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pattern_in  input  32  LED pattern from the LED register (1 = LED on).
REQ-005 SHALL have port ctrl_we  input  1  control-register write strobe, one cycle per write.
REQ-006 SHALL have port ctrl_wdata  input  32  control write data.
REQ-007 SHALL have port ctrl_rdata  output  32  control readback.
REQ-008 SHALL have port led_out  output  32  registered, active-low LED pin drive (0 = lit).

Function
REQ-009 SHALL hold control fields duty = ctrl[3:0], blink_en = ctrl[4], period = ctrl[11:8]; all other written bits are ignored.
REQ-010 SHALL drive ctrl_rdata = {phase, 19'b0, period, 3'b0, blink_en, duty}; it is combinational from registers and shows a write on the cycle after ctrl_we.
REQ-011 SHALL count prescaler pcnt 0..PRESCALE-1, wrapping to 0; tick = 1 for the single cycle pcnt == PRESCALE-1.
REQ-012 SHALL advance the 4-bit PWM counter pwm_cnt by 1 on each tick, wrapping 15 -> 0.
REQ-013 SHALL compute pwm_on = 1 when duty == 15, else pwm_on = (pwm_cnt < duty); duty 0 means always off.
REQ-014 SHALL update blink state on a tick with pwm_cnt == 15: if blink_cnt == period, set blink_cnt to 0 and toggle phase; otherwise increment blink_cnt.
REQ-015 SHALL therefore hold each blink half-period for (period+1)*16 ticks, i.e. (period+1)*16*PRESCALE cycles.
REQ-016 SHALL compute mask = pwm_on & (~blink_en | phase).
REQ-017 SHALL register led_out <= ~(pattern_in & {32{mask}}) every cycle, giving 1-cycle latency from pattern_in or counter state to the pins.
REQ-018 SHALL, on a ctrl_we cycle, load the new fields, clear blink_cnt and set phase = 1; pcnt and pwm_cnt continue undisturbed.
REQ-019 SHALL use the pre-write duty and blink values for led_out in the ctrl_we cycle; new values take effect from the next cycle.
REQ-020 SHALL apply the ctrl_we effects of REQ-018 when ctrl_we coincides with a blink-update tick; the write wins over the toggle.
REQ-021 SHALL continue blink_cnt and phase updates while blink_en = 0, so that enabling blink restarts cleanly via REQ-018.

Reset
REQ-022 SHALL, while reset = 0, asynchronously force pcnt = 0, pwm_cnt = 0, blink_cnt = 0, phase = 1, duty = 15, blink_en = 0, period = 0, led_out = 32'hFFFFFFFF (all LEDs dark).
REQ-023 SHALL resume counting on the first rising edge after reset deasserts; the first led_out update then follows pattern_in with full brightness.
REQ-024 SHALL, on reset asserted mid-PWM or mid-blink, discard all in-progress state with no partial pulse on led_out.

Verification (PRESCALE = 4)
REQ-025 SHALL cover: after reset, pattern_in = 32'h0000000F, no writes -> led_out = 32'hFFFFFFF0 from the second edge on; ctrl_rdata = 32'h8000000F.
REQ-026 SHALL cover: write duty = 4, pattern_in = 32'hFFFFFFFF -> led_out = 0 for exactly 16 of every 64 cycles (pwm_cnt 0..3), otherwise 32'hFFFFFFFF.
REQ-027 SHALL cover: write duty = 0 -> led_out stays 32'hFFFFFFFF; write duty = 15 -> led_out stays 32'h00000000 for an all-ones pattern.
REQ-028 SHALL cover: write ctrl = 32'h0000011F (blink on, period 1, full duty) -> led_out alternates lit/dark every 128 cycles, starting lit; ctrl_rdata[31] tracks phase.
REQ-029 SHALL cover: ctrl_we on the blink-toggle tick -> phase reads 1 and blink_cnt restarts; reset pulse mid-blink -> led_out = 32'hFFFFFFFF immediately and ctrl_rdata = 32'h8000000F.
